// File: rtl/raminfr.sv
// Inferred dual-port register-file RAM for the UART FIFOs: one synchronous write port, one read port.
// Define RAMINFR_REG_OUT_EN to register the read data (1-cycle read latency); default is a combinational read.
module raminfr #(
   parameter int addr_width = 4,
   parameter int data_width = 8,
   parameter int depth      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [addr_width-1:0] top,
   input  logic [addr_width-1:0] bottom,
   input  logic [data_width-1:0] dat_i,
   output logic [data_width-1:0] dat_o
);

   // One extra bit so depth == 2**addr_width is representable in the range compare.
   localparam logic [addr_width:0] depth_lim = (addr_width + 1)'(depth);

   logic [data_width-1:0] mem [0:depth-1];
   logic [data_width-1:0] rd_word;
   logic                  wr_ok;
   logic                  rd_ok;

   assign wr_ok = we && ({1'b0, top} < depth_lim);
   assign rd_ok = {1'b0, bottom} < depth_lim;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < depth; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[top] <= dat_i;
      end
   end

   // Out-of-range read addresses return zero rather than an undefined word.
   always_comb begin
      rd_word = '0;
      if (rd_ok) begin
         rd_word = mem[bottom];
      end
   end

`ifdef RAMINFR_REG_OUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dat_o <= '0;
      end else begin
         dat_o <= rd_word;
      end
   end
`else
   assign dat_o = rd_word;
`endif

endmodule

// File: tb/tb_raminfr.sv
// Scoreboard bench for raminfr: stimulus pushes expected read data, a monitor pops and compares.
module tb_raminfr;

   logic       clk;
   logic       rst;
   logic       we;
   logic [3:0] top;
   logic [3:0] bottom;
   logic [7:0] dat_i;
   logic [7:0] dat_o;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } exp_t;

   exp_t       sb_q[$];
   event       chk_ev;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model [16];

   raminfr #(4, 8, 16) dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .top    (top),
      .bottom (bottom),
      .dat_i  (dat_i),
      .dat_o  (dat_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(chk_ev);
         while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (dat_o !== e.exp) begin
               errors++;
               $display("FAIL %s: dat_o=%h expected=%h at %0t", e.name, dat_o, e.exp, $time);
            end
         end
      end
   end

   task automatic expect_rd(input logic [7:0] v, input string nm);
      sb_q.push_back('{nm, v});
      -> chk_ev;
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
   endfunction

   // One clock: drive at negedge, expected value is the pre-write word at bottom.
   task automatic cycle(input logic w, input logic [3:0] t, input logic [7:0] d,
                        input logic [3:0] b, input string nm);
      logic [7:0] pre;
      @(negedge clk);
      we = w; top = t; dat_i = d; bottom = b;
      pre = model[b];
`ifndef RAMINFR_REG_OUT_EN
      #1 expect_rd(pre, nm);
`endif
      @(posedge clk);
      if (w) model[t] = d;
`ifdef RAMINFR_REG_OUT_EN
      #1 expect_rd(pre, nm);
`endif
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; top = '0; bottom = '0; dat_i = '0;
      model_clear();
      #2 expect_rd(8'h00, "reset_hold");
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset mid-cycle wipes a freshly written word.
      cycle(1'b1, 4'd3, 8'hA5, 4'd3, "pre_rst_write");
      cycle(1'b0, 4'd0, 8'h00, 4'd3, "pre_rst_read");
      @(negedge clk);
      #2 rst = 1'b1; bottom = 4'd3; we = 1'b0;
      model_clear();
      #1 expect_rd(8'h00, "rst_async");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) cycle(1'b0, 4'd0, 8'h00, 4'(i), "post_rst_zero");

      for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 8'(i) ^ 8'h5A, 4'd0, "fill");
      for (int i = 0; i < 16; i++) cycle(1'b0, 4'd0, 8'h00, 4'(i), "fill_readback");

      for (int i = 0; i < 3; i++) cycle(1'b0, 4'd7, 8'hFF, 4'd7, "we_gating");
      @(negedge clk);
      #1 expect_rd(8'h5D, "we_gating_const");

      cycle(1'b1, 4'd2, 8'h11, 4'd0, "rdw_setup");
      cycle(1'b1, 4'd2, 8'h22, 4'd2, "rdw_old");
      cycle(1'b0, 4'd2, 8'h00, 4'd2, "rdw_new");

      cycle(1'b1, 4'd15, 8'hC3, 4'd0, "wrap_w15");
      cycle(1'b1, 4'd0, 8'h3C, 4'd0, "wrap_w0");
      cycle(1'b0, 4'd0, 8'h00, 4'd15, "wrap_r15");
      cycle(1'b0, 4'd0, 8'h00, 4'd0, "wrap_r0");
      for (int i = 0; i < 16; i++) cycle(1'b0, 4'd0, 8'h00, 4'(i), "wrap_sweep");

`ifdef RAMINFR_REG_OUT_EN
      // Registered output must hold mem[0] until the edge after bottom moves to 15.
      cycle(1'b0, 4'd0, 8'h00, 4'd0, "regout_b0");
      @(negedge clk);
      bottom = 4'd15;
      #1 expect_rd(model[0], "regout_hold");
      @(posedge clk);
      #1 expect_rd(model[15], "regout_update");
`endif

      for (int n = 0; n < 300; n++) begin
         cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
               4'($urandom_range(0, 15)), "random");
      end

      #5;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/raminfr.md
Name: raminfr

Overview:
- Inferred dual-port register-file RAM: one synchronous write port, one combinational read port.
- Serves as the storage array for the UART TX/RX FIFOs.
- The FIFO controller drives the write pointer (top), write enable and write data, and reads the head entry at the read pointer (bottom).
- No flow control inside the block; full/empty protection is the FIFO controller's job.

Parameters:
- addr_width, 4, pointer/address width in bits (positional parameter 1).
- data_width, 8, word width in bits (positional parameter 2).
- depth, 16, number of words; must be at most 2^addr_width (positional parameter 3).

Ports:
- clk  input  1  Single clock; all state changes on its rising edge except reset.
- rst  input  1  Reset, asynchronous, active-high.
- we  input  1  Write enable, active high, sampled on rising clk.
- top  input  addr_width  Write address.
- bottom  input  addr_width  Read address.
- dat_i  input  data_width  Write data.
- dat_o  output  data_width  Read data, equal to mem[bottom].

Behaviour:
- Storage: depth words of data_width bits, mem[0..depth-1].
- Reset:
  - rst high clears every word to 0 immediately, without waiting for a clock edge.
  - dat_o reads 0 while reset is held.
  - Writes are blocked while rst is high.
  - Release is synchronous to the next rising edge: the first write can occur on the first rising edge where rst is low.
- Write: on a rising clk with we=1 and top<depth, mem[top] <= dat_i.
  - we=0 leaves memory unchanged.
  - top>=depth (only possible when depth<2^addr_width): the write is silently dropped.
- Read:
  - dat_o = mem[bottom] combinationally; zero-cycle latency after a bottom change.
  - bottom>=depth gives dat_o = 0.
- Read-during-write to the same address (top==bottom, we=1):
  - dat_o shows the old word until the clock edge and the new word after it. There is no write-through bypass.
- One write per cycle; the read port never modifies memory.
- Pointer wrap-around is handled by the caller. Address arithmetic is not performed inside the block.
- Data is stored exactly; no parity or width conversion.
- No X may propagate from uninitialised storage after the first reset.

Optional Feature:
- Macro: RAMINFR_REG_OUT_EN.
- Defined:
  - dat_o is a register loaded with mem[bottom] (the pre-write contents) on every rising clk.
  - Read latency is 1 cycle.
  - The register clears to 0 asynchronously on rst.
  - An out-of-range bottom loads 0.
- Undefined: combinational read as specified in Behaviour.

Test Plan:
- Reset: write 0xA5 to address 3, assert rst mid-cycle, set bottom=3 -> dat_o=0x00 immediately, without a clock edge; all 16 addresses read 0 after release.
- Fill and readback: write dat_i=addr^0x5A to addresses 0..15, then sweep bottom 0..15 -> dat_o=0x5A,0x5B,...,0x55 with zero-cycle latency.
- Write enable gating: we=0, top=7, dat_i=0xFF for 3 clocks -> mem[7] keeps its prior value 0x5D.
- Read-during-write: top=bottom=2, mem[2]=0x11, write 0x22 -> dat_o=0x11 before the edge and 0x22 after it.
- Overwrite and wrap: write address 15 then address 0 with 0xC3 and 0x3C -> bottom=15 gives 0xC3, bottom=0 gives 0x3C; other words are unchanged.
- RAMINFR_REG_OUT_EN defined: change bottom from 0 to 15 -> dat_o updates one clock later; rst high clears dat_o to 0 asynchronously.
